// File: rtl/bridge_timer_dev.sv
// Timer/counter responder on the system bridge: CTRL/PRESET/COUNT registers,
// a load/count/interrupt FSM, and a registered level interrupt request.
module bridge_timer_dev #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic              IRQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PRESET = 2'd1,
    REG_COUNT  = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;     // {IM, MODE[1:0], EN}
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        irq_q;

  reg_sel_t    sel;
  logic        ctrl_wr, preset_wr, en, auto_reload, int_entry;

  assign sel         = reg_sel_t'(Addr[3:2]);
  assign ctrl_wr     = WE && (sel == REG_CTRL);
  assign preset_wr   = WE && (sel == REG_PRESET);
  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'd1);
  assign int_entry   = (state_q == S_CNT) && en && (count_q == 32'd0);

  // Only Addr[3:2] selects a register; the rest is decoded by the bridge.
  logic unused_addr;
  assign unused_addr = ^{Addr[ADDR_W-1:4], Addr[1:0]};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      S_IDLE: if (en) state_d = S_LOAD;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en)                    state_d = S_IDLE;
        else if (count_q != 32'd0)  count_d = count_q - 32'd1;
        else                        state_d = S_INT;
      end
      S_INT: begin
        if (auto_reload) begin
          irq_flag_d = 1'b0;
          state_d    = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The CPU write overrides the FSM's own CTRL update in the same cycle.
    if (ctrl_wr) begin
      ctrl_d     = Din[3:0];
      irq_flag_d = 1'b0;
    end
    if (preset_wr) preset_d = Din;

    // Entering INT sets the flag even if the same edge carries a CTRL write.
    if (int_entry) irq_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      // Registered from next-state values: rises on the same edge as the flag.
      irq_q      <= irq_flag_d & ctrl_d[3];
    end
  end

  always_comb begin
    Dout = '0;
    unique case (sel)
      REG_CTRL:   Dout = {28'd0, ctrl_q};
      REG_PRESET: Dout = preset_q;
      REG_COUNT:  Dout = count_q;
      REG_RSVD:   Dout = '0;
      default:    Dout = '0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_bridge_timer_dev.sv
// Directed bench for bridge_timer_dev: a register-access vector table followed
// by hand-written timing sequences (one-shot, auto-reload, disable, mask, reset).
module tb_bridge_timer_dev;

  localparam logic [31:0] A_CTRL = 32'h0000_7F10;
  localparam logic [31:0] A_PRE  = 32'h0000_7F14;
  localparam logic [31:0] A_CNT  = 32'h0000_7F18;
  localparam logic [31:0] A_RSV  = 32'h0000_7F1C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  bridge_timer_dev #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one bus cycle, let one rising edge capture it, sample just after.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    WE   = we;
    Addr = a;
    Din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, a, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, A_CTRL,        32'hFFFF_FFFF, 32'h0000_000F, 1'b0};
    vecs[1]  = '{1'b1, A_CTRL,        32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, A_CTRL,        32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, A_CNT,         32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b1, A_PRE,         32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[5]  = '{1'b1, A_PRE | 32'h3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[6]  = '{1'b1, A_CNT,         32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b1, A_RSV,         32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, A_PRE,         32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b1, A_CTRL,        32'h0000_0006, 32'h0000_0006, 1'b0};
    vecs[10] = '{1'b1, A_CTRL,        32'hFFFF_FFF0, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, A_RSV,         32'h0000_0000, 32'h0000_0000, 1'b0};

    reset = 1'b0;
    WE    = 1'b0;
    Addr  = A_CTRL;
    Din   = '0;
    #12;
    check("reset irq", {31'd0, IRQ}, 32'd0);
    check("reset ctrl", Dout, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Register access table
    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].addr, vecs[i].din);
      check($sformatf("vec%0d dout", i), Dout, vecs[i].exp_dout);
      check($sformatf("vec%0d irq", i), {31'd0, IRQ}, {31'd0, vecs[i].exp_irq});
    end

    // One-shot, PRESET=5: IRQ on the 8th edge after the enabling write
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    check("os irq at write", {31'd0, IRQ}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      rd(A_CNT);
      if (k >= 2) check($sformatf("os count e%0d", k), Dout, (k >= 7) ? 32'd0 : 32'(7 - k));
      check($sformatf("os irq e%0d", k), {31'd0, IRQ}, {31'd0, k == 8});
    end
    rd(A_CTRL);
    check("os ctrl after", Dout, 32'h8);
    for (int k = 0; k < 3; k++) begin
      rd(A_CTRL);
      check("os irq held", {31'd0, IRQ}, 32'd1);
    end
    wr(A_CTRL, 32'h8);
    check("os irq cleared", {31'd0, IRQ}, 32'd0);
    rd(A_CTRL);
    check("os irq stays low", {31'd0, IRQ}, 32'd0);

    // Auto-reload, PRESET=2: one-cycle pulse every 5 cycles
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      rd(A_CTRL);
      check($sformatf("ar ctrl e%0d", k), Dout, 32'hB);
      check($sformatf("ar irq e%0d", k), {31'd0, IRQ}, {31'd0, (k % 5) == 0});
    end
    wr(A_CTRL, 32'h0);
    for (int k = 0; k < 4; k++) begin
      rd(A_CTRL);
      check("ar stopped irq", {31'd0, IRQ}, 32'd0);
    end

    // Disable mid-count: write lands on the edge that also decrements 6 -> 5
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      rd(A_CNT);
      if (k >= 2) check($sformatf("dis count e%0d", k), Dout, 32'(12 - k));
    end
    wr(A_CTRL, 32'h8);
    for (int k = 0; k < 10; k++) begin
      rd(A_CNT);
      check("dis count held", Dout, 32'd5);
      check("dis irq", {31'd0, IRQ}, 32'd0);
    end

    // Masked one-shot: flag sets internally, IRQ never rises
    wr(A_PRE, 32'd1);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      rd(A_CTRL);
      check($sformatf("mask irq e%0d", k), {31'd0, IRQ}, 32'd0);
    end
    check("mask en cleared", Dout, 32'h0);
    wr(A_CTRL, 32'h8);
    check("mask unmask after clear", {31'd0, IRQ}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      rd(A_CTRL);
      check("mask irq stays low", {31'd0, IRQ}, 32'd0);
    end

    // CTRL write clearing EN on the same edge INT is entered
    wr(A_PRE, 32'd1);
    wr(A_CTRL, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      rd(A_CNT);
      check($sformatf("race irq e%0d", k), {31'd0, IRQ}, 32'd0);
    end
    wr(A_CTRL, 32'h8);
    check("race ctrl", Dout, 32'h8);
    check("race irq set", {31'd0, IRQ}, 32'd1);
    rd(A_CTRL);
    check("race irq held", {31'd0, IRQ}, 32'd1);
    wr(A_CTRL, 32'h8);
    check("race irq cleared", {31'd0, IRQ}, 32'd0);

    // PRESET write during CNT leaves COUNT alone until the next LOAD
    wr(A_PRE, 32'd4);
    wr(A_CTRL, 32'h9);
    rd(A_CNT);
    rd(A_CNT);
    check("pw count e2", Dout, 32'd4);
    wr(A_PRE, 32'd1);
    rd(A_CNT);
    check("pw count e4", Dout, 32'd2);
    rd(A_CNT);
    rd(A_CNT);
    check("pw count e6", Dout, 32'd0);
    check("pw irq e6", {31'd0, IRQ}, 32'd0);
    rd(A_CNT);
    check("pw irq e7", {31'd0, IRQ}, 32'd1);
    wr(A_CTRL, 32'h0);
    wr(A_CTRL, 32'h9);
    rd(A_CNT);
    rd(A_CNT);
    check("pw new preset", Dout, 32'd1);
    rd(A_CNT);
    rd(A_CNT);
    check("pw new irq", {31'd0, IRQ}, 32'd1);
    wr(A_CTRL, 32'h0);

    // Reset asserted mid-count
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    for (int k = 0; k < 4; k++) rd(A_CNT);
    @(negedge clk);
    #2;
    reset = 1'b0;
    WE    = 1'b0;
    #1;
    check("rst irq", {31'd0, IRQ}, 32'd0);
    Addr = A_CTRL; #1; check("rst ctrl", Dout, 32'd0);
    Addr = A_PRE;  #1; check("rst preset", Dout, 32'd0);
    Addr = A_CNT;  #1; check("rst count", Dout, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst held count", Dout, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rd(A_CTRL);
      check("post rst irq", {31'd0, IRQ}, 32'd0);
    end
    check("post rst ctrl", Dout, 32'd0);
    rd(A_CNT);
    check("post rst count", Dout, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bridge_timer_dev.md
Name: bridge_timer_dev

Overview:
- Timer/counter device on the responder side of the system bridge. Occupies one 12-byte window, either TC0 (0x7F00–0x7F0B) or TC1 (0x7F10–0x7F1B).
- Accepts the bridge's full address, write strobe and write data. Returns read data and raises an interrupt request toward the CPU's external-interrupt input.
- Two instances are built, one per window. The bridge alone performs window decode; this block decodes only within its window.

Parameters:
- ADDR_W, 32, width of incoming address bus; only bits [3:2] are decoded.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- Addr  in  32  byte address from bridge; Addr[3:2] selects register, Addr[1:0] ignored
- WE  in  1  write strobe from bridge (already qualified by window hit)
- Din  in  32  write data from bridge
- Dout  out  32  combinational read data of the register selected by Addr[3:2]
- IRQ  out  1  interrupt request, level, registered

Behaviour:
Register map (word offsets):
- 0x0 CTRL: bit0 EN, bits[2:1] MODE, bit3 IM (interrupt mask). Bits[31:4] read 0, writes to them discarded.
- 0x4 PRESET: 32-bit, read/write.
- 0x8 COUNT: 32-bit, read-only; writes ignored.
- Addr[3:2]=3 reads 0; writes ignored.

Writes and reads:
- Writes are captured on the rising clk edge when WE=1.
- A CPU write to CTRL has priority over any FSM update of CTRL in the same cycle.

Reset:
- While reset=0, immediately force CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE.
- IRQ=0 and Dout reflects zeroed registers.
- Reset asserted mid-count aborts all activity; no interrupt survives.

FSM states:
- IDLE: if EN=1 -> LOAD; else stay.
- LOAD: COUNT<=PRESET -> CNT.
- CNT:
  - if EN=0 -> IDLE, COUNT holds its value.
  - else if COUNT!=0 -> COUNT<=COUNT-1 (32-bit, no wrap below 0), stay.
  - else -> INT, irq_flag<=1.
- INT, MODE=0 (one-shot; MODE=2/3 behave as 0): CTRL.EN<=0 -> IDLE. irq_flag stays 1 until the next CPU write to CTRL clears it.
- INT, MODE=1 (auto-reload): -> LOAD, irq_flag<=0. irq_flag is therefore a one-cycle pulse.

Timing:
- IRQ = irq_flag & CTRL.IM, registered so no combinational path from Din.
- From the edge that writes EN=1 with PRESET=N, irq_flag rises after N+3 edges.
- MODE=1 period between successive INT entries is N+3 cycles.
- PRESET=0: INT is entered 3 edges after enable.

Boundary conditions:
- A PRESET write during CNT does not disturb COUNT; the new value applies at the next LOAD.
- A CTRL write that clears EN in the same cycle as INT is entered: the CPU write wins, and irq_flag is still set (mode 0).
- Writing IM=0 masks IRQ without clearing irq_flag; IM=1 later re-exposes a pending mode-0 flag unless that CTRL write cleared it. Any CTRL write clears irq_flag.
- COUNT=0xFFFFFFFF preset counts the full range with no overflow behaviour.

Test Plan:
- Reset: drive reset=0 mid-count with PRESET=5, EN=1 -> IRQ=0, Dout at 0x0/0x4/0x8 all read 0, state IDLE, no later IRQ.
- One-shot:
  - Write PRESET=5, then CTRL=0x9 (IM=1, MODE=0, EN=1) -> IRQ rises exactly 8 edges after the CTRL write.
  - COUNT reads 5,4,3,2,1,0 during CNT.
  - CTRL reads 0x8 afterwards; IRQ stays high until CTRL is written with 0x8, then drops next edge.
- Auto-reload: PRESET=2, CTRL=0xB -> IRQ one-cycle pulses every 5 cycles, repeating for at least 3 periods; EN stays 1.
- Disable mid-count: PRESET=10, enable, write CTRL=0x8 when COUNT=6 -> state IDLE, COUNT holds 6 (or 5 if the decrement edge coincides; check exact cycle), no IRQ.
- Register access:
  - Write 0xFFFFFFFF to CTRL -> reads 0x0000000F.
  - Write to COUNT (0x8) and offset 0xC -> no change; 0xC reads 0.
  - Addr[1:0]=3 on a PRESET write still targets PRESET.
- Masking: mode 0 with IM=0 completes -> IRQ stays 0 while irq_flag is set internally; writing CTRL=0x8 clears the flag, so IRQ remains 0.
